// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl
//   Command-driven sequencer for a Gray-code counter. Owns the binary count
//   register and a registered Gray encoding of it. Run commands step the
//   count up or down a programmed number of times. Pause freezes stepping,
//   abort ends a run early, and completion is flagged by a one-cycle done
//   pulse.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     00 NOP, 01 RUN_UP, 10 RUN_DOWN, 11 CLEAR
//   cmd_len    step count for RUN ops, 0..2^WIDTH
//   pause      level, freezes stepping while high
//   abort      level, terminates an active run (wins over pause)
//   gray_out   registered Gray code of the count
//   bin_out    registered binary count
//   remaining  steps left in the current run
//   busy       high while running
//   done       one-cycle pulse at end of a run (also for zero-length runs)
//   aborted    qualifies done: high with done only when the run was aborted
module gray_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH:0]   cmd_len,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH:0]   remaining,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0]       state;
    logic             dir_down;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             last_step;

    // Only IDLE takes commands; holding cmd_valid elsewhere is harmless.
    assign cmd_ready = (state == S_IDLE);

    // Next count wraps naturally through the WIDTH-bit arithmetic. The Gray
    // code is computed from the next binary value so both registers update
    // together and never disagree.
    assign bin_nxt   = dir_down ? (bin_out - WIDTH'(1)) : (bin_out + WIDTH'(1));
    assign gray_nxt  = bin_nxt ^ (bin_nxt >> 1);
    assign last_step = (remaining == (WIDTH+1)'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            dir_down  <= 1'b0;
            bin_out   <= '0;
            gray_out  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            // done/aborted are single-cycle; they are only set on the edge
            // entering DONE, and DONE always lasts one cycle.
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_CLEAR: begin
                                bin_out  <= '0;
                                gray_out <= '0;
                            end
                            OP_UP, OP_DOWN: begin
                                dir_down <= (cmd_op == OP_DOWN);
                                if (cmd_len == '0) begin
                                    // Zero-length run: report completion only.
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    remaining <= cmd_len;
                                    state     <= S_RUN;
                                    busy      <= 1'b1;
                                end
                            end
                            default: ; // NOP is dropped
                        endcase
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Count and remaining are left as they were so the
                        // master can see how far the run got.
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (!pause) begin
                        bin_out   <= bin_nxt;
                        gray_out  <= gray_nxt;
                        remaining <= remaining - (WIDTH+1)'(1);
                        if (last_step) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_counter_ctrl.sv
module tb_gray_counter_ctrl;

    localparam int WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH:0]   cmd_len;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH:0]   remaining;
    logic             busy;
    logic             done;
    logic             aborted;

    int n_cmp = 0;
    int n_err = 0;

    gray_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .pause     (pause),
        .abort     (abort),
        .gray_out  (gray_out),
        .bin_out   (bin_out),
        .remaining (remaining),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, land 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one command for exactly one edge (controller must be IDLE).
    task automatic cmd(input logic [1:0] op, input logic [WIDTH:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
    endtask

    logic [WIDTH-1:0] prev_gray;

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0;
        pause = 1'b0; abort = 1'b0;

        // Reset state
        #1;
        chk("rst_bin", bin_out, 0);
        chk("rst_gray", gray_out, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abt", aborted, 0);
        tick(); tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("rst_rdy", cmd_ready, 1);

        // RUN_UP len=5 from 0
        begin
            logic [3:0] g5 [5] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7};
            cmd(2'b01, 5);
            chk("up5_rem0", remaining, 5);
            chk("up5_busy", busy, 1);
            chk("up5_rdy", cmd_ready, 0);
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("up5_gray", gray_out, g5[i]);
                chk("up5_done", done, (i == 4));
            end
            chk("up5_bin", bin_out, 5);
            chk("up5_abt", aborted, 0);
            chk("up5_busy_end", busy, 0);
            chk("up5_rdy_done", cmd_ready, 0);
            tick();
            chk("up5_done_clr", done, 0);
            chk("up5_rdy_idle", cmd_ready, 1);
        end

        // Preset 14, then wrap 15->0->1
        cmd(2'b11, 0);
        chk("clr_bin", bin_out, 0);
        cmd(2'b01, 14);
        for (int i = 0; i < 15; i++) tick();
        chk("pre_bin", bin_out, 14);
        chk("pre_gray", gray_out, 4'h9);
        cmd(2'b01, 3);
        chk("wrap_rem3", remaining, 3);
        tick(); chk("wrap_g15", gray_out, 4'h8); chk("wrap_rem2", remaining, 2);
        tick(); chk("wrap_g0", gray_out, 4'h0); chk("wrap_rem1", remaining, 1);
        tick(); chk("wrap_g1", gray_out, 4'h1); chk("wrap_rem0", remaining, 0);
        chk("wrap_done", done, 1);
        tick();

        // CLEAR then RUN_DOWN len=2
        cmd(2'b11, 0);
        cmd(2'b10, 2);
        tick(); chk("dn_g15", gray_out, 4'h8); chk("dn_b15", bin_out, 15); chk("dn_d0", done, 0);
        tick(); chk("dn_g14", gray_out, 4'h9); chk("dn_b14", bin_out, 14); chk("dn_d1", done, 1);
        tick();

        // Pause for 3 cycles after step 2
        cmd(2'b11, 0);
        cmd(2'b01, 4);
        tick(); chk("pz_g1", gray_out, 4'h1);
        tick(); chk("pz_g2", gray_out, 4'h3);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pz_hold", gray_out, 4'h3);
            chk("pz_rem", remaining, 2);
            chk("pz_nodone", done, 0);
        end
        pause = 1'b0;
        tick(); chk("pz_g3", gray_out, 4'h2); chk("pz_d6", done, 0);
        tick(); chk("pz_g4", gray_out, 4'h6); chk("pz_d7", done, 1);
        tick(); chk("pz_d8", done, 0);

        // Abort after step 3 (pause also high: abort wins)
        cmd(2'b11, 0);
        cmd(2'b01, 8);
        for (int i = 0; i < 3; i++) tick();
        abort = 1'b1; pause = 1'b1;
        tick();
        chk("ab_done", done, 1);
        chk("ab_abt", aborted, 1);
        chk("ab_bin", bin_out, 3);
        chk("ab_gray", gray_out, 4'h2);
        chk("ab_busy", busy, 0);
        abort = 1'b0; pause = 1'b0;
        tick();
        chk("ab_done_clr", done, 0);
        chk("ab_abt_clr", aborted, 0);
        chk("ab_rdy", cmd_ready, 1);
        cmd(2'b11, 0);
        chk("ab_clr_gray", gray_out, 0);

        // Zero-length run leaves count alone
        cmd(2'b01, 2);
        tick(); tick(); tick();
        chk("z_pre_gray", gray_out, 4'h3);
        cmd(2'b01, 0);
        chk("z_done", done, 1);
        chk("z_gray", gray_out, 4'h3);
        chk("z_busy", busy, 0);
        chk("z_rdy", cmd_ready, 0);
        tick();
        chk("z_done_clr", done, 0);
        chk("z_rdy_idle", cmd_ready, 1);

        // Full cycle len=16 from 2, CLEAR held during the first steps is ignored
        cmd(2'b01, 16);
        chk("full_rem", remaining, 16);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        prev_gray = gray_out;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                chk("full_noclr", bin_out, 5);
                cmd_valid = 1'b0; cmd_op = 2'b00;
            end
            tick();
            chk("full_1bit", $countones(gray_out ^ prev_gray), 1);
            prev_gray = gray_out;
        end
        chk("full_bin", bin_out, 2);
        chk("full_gray", gray_out, 4'h3);
        chk("full_done", done, 1);
        tick();

        // Asynchronous reset mid-run
        cmd(2'b01, 8);
        tick(); tick();
        #2;
        reset = 1'b0;
        #1;
        chk("ar_bin", bin_out, 0);
        chk("ar_gray", gray_out, 0);
        chk("ar_rem", remaining, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("ar_rdy", cmd_ready, 1);
        chk("ar_bin_hold", bin_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
